// File: rtl/framebuffer_write_queue.sv
// Pixel write queue that serializes video_generator writes onto a single-port framebuffer RAM,
// giving scanout reads strict priority. Define FB_WRQ_CLEAR_EN to compile in the full-frame clear engine.
module framebuffer_write_queue #(
  parameter int FRAMEBUFFER_DATA_BITS = 16,
  parameter int FRAMEBUFFER_SIZE      = 10000,
  parameter int FRAMEBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter int FIFO_DEPTH            = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_wr_en,
  input  logic [FRAMEBUFFER_ADDR_BITS-1:0] in_wr_addr,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] in_wr_data,
  input  logic                             scan_rd_req,
  input  logic [FRAMEBUFFER_ADDR_BITS-1:0] scan_rd_addr,
  output logic                             scan_rd_valid,
  output logic [FRAMEBUFFER_DATA_BITS-1:0] scan_rd_data,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [FRAMEBUFFER_ADDR_BITS-1:0] ram_addr,
  output logic [FRAMEBUFFER_DATA_BITS-1:0] ram_wr_data,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] ram_rd_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
`ifdef FB_WRQ_CLEAR_EN
  input  logic                             clear_start,
  input  logic [FRAMEBUFFER_DATA_BITS-1:0] clear_color,
  output logic                             clear_busy,
  output logic                             clear_done,
`endif
  output logic [1:0]                       dbg_state
);

  localparam int DW = FRAMEBUFFER_DATA_BITS;
  localparam int AW = FRAMEBUFFER_ADDR_BITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW:0]   SIZE_W  = FRAMEBUFFER_SIZE[AW:0];
  localparam logic [CW-1:0] DEPTH_W = FIFO_DEPTH[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1
`ifdef FB_WRQ_CLEAR_EN
    ,S_CLEAR = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_d;

  logic in_range, push_req, push, pop, drop, full, in_clear;

`ifdef FB_WRQ_CLEAR_EN
  localparam int LAST_INT = FRAMEBUFFER_SIZE - 1;
  localparam logic [AW-1:0] LAST_ADDR = LAST_INT[AW-1:0];
  logic [AW-1:0] clear_cnt;
  logic [DW-1:0] clear_color_q;
  logic          clear_done_q;
  logic          grant_clear, clear_last;
  assign in_clear    = (state_q == S_CLEAR);
  assign grant_clear = !scan_rd_req && in_clear;
  assign clear_last  = grant_clear && (clear_cnt == LAST_ADDR);
  assign clear_busy  = in_clear;
  assign clear_done  = clear_done_q;
`else
  assign in_clear = 1'b0;
`endif

  // Scanout reads always win; FIFO pops yield to both scanout and an active clear.
  assign pop      = !scan_rd_req && !in_clear && (fifo_count != '0);
  assign in_range = ({1'b0, in_wr_addr} < SIZE_W);
  assign push_req = in_wr_en && in_range;
  assign full     = (fifo_count == DEPTH_W);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;
  assign count_d  = fifo_count + CW'(push) - CW'(pop);

  assign scan_rd_data = ram_rd_data;
  assign dbg_state    = state_q;

  always_comb begin
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wr_data = '0;
    if (!rst) begin
      if (scan_rd_req) begin
        ram_en   = 1'b1;
        ram_addr = scan_rd_addr;
      end
`ifdef FB_WRQ_CLEAR_EN
      else if (grant_clear) begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = clear_cnt;
        ram_wr_data = clear_color_q;
      end
`endif
      else if (pop) begin
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_addr    = fifo_addr[rd_ptr];
        ram_wr_data = fifo_data[rd_ptr];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef FB_WRQ_CLEAR_EN
      S_CLEAR: begin
        if (clear_last) state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
      end
`endif
      default: begin
`ifdef FB_WRQ_CLEAR_EN
        if (clear_start) state_d = S_CLEAR;
        else
`endif
        state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
      end
    endcase
  end

  // Storage has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= in_wr_addr;
      fifo_data[wr_ptr] <= in_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      overflow      <= 1'b0;
      scan_rd_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      fifo_count    <= count_d;
      scan_rd_valid <= scan_rd_req;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef FB_WRQ_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clear_cnt     <= '0;
      clear_color_q <= '0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= clear_last;
      if (!in_clear && clear_start) begin
        clear_cnt     <= '0;
        clear_color_q <= clear_color;
      end else if (grant_clear) begin
        clear_cnt <= clear_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_framebuffer_write_queue.sv
// Randomized bench for framebuffer_write_queue: a queue-based reference model predicts every cycle's
// RAM port activity and status outputs; a monitor compares them and a final framebuffer image check closes out.
module tb_framebuffer_write_queue;

  localparam int DW    = 16;
  localparam int SIZE  = 100;
  localparam int AW    = 7;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_wr_en = 1'b0;
  logic [AW-1:0] in_wr_addr = '0;
  logic [DW-1:0] in_wr_data = '0;
  logic          scan_rd_req = 1'b0;
  logic [AW-1:0] scan_rd_addr = '0;
  logic          scan_rd_valid;
  logic [DW-1:0] scan_rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data = '0;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [1:0]    dbg_state;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_color = '0;
`ifdef FB_WRQ_CLEAR_EN
  logic          clear_busy, clear_done;
`endif

  framebuffer_write_queue #(
    .FRAMEBUFFER_DATA_BITS(DW), .FRAMEBUFFER_SIZE(SIZE),
    .FRAMEBUFFER_ADDR_BITS(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .scan_rd_req(scan_rd_req), .scan_rd_addr(scan_rd_addr),
    .scan_rd_valid(scan_rd_valid), .scan_rd_data(scan_rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .fifo_count(fifo_count), .overflow(overflow),
`ifdef FB_WRQ_CLEAR_EN
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Environment RAM: single port, 1-cycle read latency
  logic [DW-1:0] env_mem [1 << AW];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) env_mem[ram_addr] <= ram_wr_data;
      else        ram_rd_data <= env_mem[ram_addr];
    end
  end

  // Reference model state
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct {
    logic en, we; logic [AW-1:0] addr; logic [DW-1:0] wdata;
    logic [CW-1:0] cnt; logic ovf; logic rv; logic [DW-1:0] rdata;
    logic busy, done;
  } exp_t;

  wr_t           m_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] ref_fb [SIZE];
  bit            m_ovf, m_clr, m_done, m_pv;
  int            m_idx;
  logic [DW-1:0] m_color;
  logic [AW-1:0] m_pa;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Driver: applies one cycle of stimulus and pushes the model's prediction for that cycle
  task automatic step(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic scan, input logic [AW-1:0] sa,
                      input logic cs, input logic [DW-1:0] cc, input logic r);
    exp_t e;
    int   occ;
    bit   popped, was_clr, done_next;
    wr_t  w;
    rst = r; in_wr_en = wr; in_wr_addr = a; in_wr_data = d;
    scan_rd_req = scan; scan_rd_addr = sa; clear_start = cs; clear_color = cc;
    #1;
    e.en = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0;
    e.cnt = CW'(m_q.size()); e.ovf = m_ovf; e.rv = m_pv; e.rdata = ref_fb[m_pa];
    e.busy = m_clr; e.done = m_done;
    if (r) begin
      m_q.delete(); m_ovf = 0; m_clr = 0; m_done = 0; m_pv = 0; m_idx = 0;
    end else begin
      occ = m_q.size(); popped = 0; was_clr = m_clr; done_next = 0;
      if (scan) begin
        e.en = 1'b1; e.addr = sa;
      end else if (m_clr) begin
        e.en = 1'b1; e.we = 1'b1; e.addr = AW'(m_idx); e.wdata = m_color;
        ref_fb[m_idx] = m_color;
        m_idx++;
        if (m_idx == SIZE) begin m_clr = 0; done_next = 1; end
      end else if (occ > 0) begin
        w = m_q.pop_front();
        e.en = 1'b1; e.we = 1'b1; e.addr = w.a; e.wdata = w.d;
        ref_fb[w.a] = w.d;
        popped = 1;
      end
      if (wr && int'(a) < SIZE) begin
        if (occ < DEPTH || popped) m_q.push_back('{a: a, d: d});
        else m_ovf = 1;
      end
      if (cs && !was_clr) begin m_clr = 1; m_idx = 0; m_color = cc; end
      m_done = done_next; m_pv = scan; m_pa = sa;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0, 0);
  endtask

  // Monitor: compares observed outputs mid-cycle against the predicted record
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ram_en", 32'(ram_en), 32'(e.en));
      if (e.en) begin
        check("ram_we", 32'(ram_we), 32'(e.we));
        check("ram_addr", 32'(ram_addr), 32'(e.addr));
        if (e.we) check("ram_wr_data", 32'(ram_wr_data), 32'(e.wdata));
      end
      check("fifo_count", 32'(fifo_count), 32'(e.cnt));
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("scan_rd_valid", 32'(scan_rd_valid), 32'(e.rv));
      if (e.rv) check("scan_rd_data", 32'(scan_rd_data), 32'(e.rdata));
`ifdef FB_WRQ_CLEAR_EN
      check("clear_busy", 32'(clear_busy), 32'(e.busy));
      check("clear_done", 32'(clear_done), 32'(e.done));
`endif
    end
  end

  initial begin
    logic [AW-1:0] a, sa;
    bit cen;
`ifdef FB_WRQ_CLEAR_EN
    cen = 1;
`else
    cen = 0;
`endif
    for (int i = 0; i < (1 << AW); i++) env_mem[i] = '0;
    for (int i = 0; i < SIZE; i++) ref_fb[i] = '0;
    m_pa = '0; m_color = '0; m_idx = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then a single write
    idle(1);
    step(1, 7'd5, 16'h1234, 0, '0, 0, '0, 0);
    idle(3);

    // Scan priority: three queued writes held off by four scan reads
    step(1, 7'd10, 16'haaaa, 1, 7'd5, 0, '0, 0);
    step(1, 7'd11, 16'hbbbb, 1, 7'd6, 0, '0, 0);
    step(1, 7'd12, 16'hcccc, 1, 7'd5, 0, '0, 0);
    step(0, '0, '0, 1, 7'd10, 0, '0, 0);
    idle(5);
    for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 7'(10 + i), 0, '0, 0);

    // Overflow: seventeen writes while scan holds the port
    for (int i = 0; i < 17; i++) step(1, 7'(20 + i), 16'(16'h100 + i), 1, 7'(i), 0, '0, 0);
    idle(20);
    step(0, '0, '0, 0, '0, 0, '0, 1);

    // Full FIFO plus a write on the cycle scan releases: push and pop together
    for (int i = 0; i < 16; i++) step(1, 7'(40 + i), 16'(16'h200 + i), 1, 7'(i), 0, '0, 0);
    step(1, 7'd60, 16'h5a5a, 0, '0, 0, '0, 0);
    idle(20);

    // Out-of-range addresses never queue and never flag overflow
    step(1, 7'd100, 16'hdead, 0, '0, 0, '0, 0);
    step(1, 7'd127, 16'hbeef, 0, '0, 0, '0, 0);
    idle(2);

    // Reset with the FIFO non-empty
    for (int i = 0; i < 5; i++) step(1, 7'(70 + i), 16'(16'h300 + i), 1, 7'(i), 0, '0, 0);
    step(0, '0, '0, 1, '0, 0, '0, 1);
    idle(3);

    if (cen) begin
      // Full clear, with pushes piling up behind it
      step(0, '0, '0, 0, '0, 1, 16'hffff, 0);
      for (int i = 0; i < 110; i++)
        step((i % 5) == 0, 7'(i % SIZE), 16'(i), (i % 17) == 3, 7'(i % SIZE), i == 30, 16'h1111, 0);
      idle(20);
      // Clear aborted by reset at address 20
      step(0, '0, '0, 0, '0, 1, 16'h0f0f, 0);
      while (m_idx < 20) step(0, '0, '0, 0, '0, 0, '0, 0);
      step(0, '0, '0, 0, '0, 0, '0, 1);
      idle(5);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(SIZE, 127)) : AW'($urandom_range(0, SIZE - 1));
      sa = AW'($urandom_range(0, SIZE - 1));
      step($urandom_range(0, 99) < 55, a, DW'($urandom), $urandom_range(0, 99) < 30, sa,
           cen && ($urandom_range(0, 299) == 0), DW'($urandom), $urandom_range(0, 499) == 0);
    end

    idle(150);
    @(negedge clk); #1;
    for (int i = 0; i < SIZE; i++) check("fb_image", 32'(env_mem[i]), 32'(ref_fb[i]));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
